dmem_arb: RTL and testbench

DMEM_ARB -- requirements
Module: dmem_arb

---
 rtl/dmem_arb_pkg.sv | 25 ++
 rtl/dmem_arb_if.sv | 42 ++++
 rtl/dmem_lane.sv | 45 ++++
 rtl/dmem_arb.sv | 145 ++++++++++++++
 tb/tb_dmem_arb.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared constants for the data-memory arbiter: bus width, FSM states,
// access size codes and the access-shape check.
package dmem_arb_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        MERGE  = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // True for size code 3 or an access not aligned to its own width.
    function automatic logic bad_shape(input logic [1:0] size, input logic [1:0] off);
        return (size == 2'd3) ||
               (size == SZ_HALF && off[0]) ||
               (size == SZ_WORD && off != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_arb_if.sv
// Two requester ports plus the memory side of the arbiter, bundled so the
// arbiter (slave) and the requesters/memory (master) share one declaration.
interface dmem_arb_if;
    import dmem_arb_pkg::*;

    // Request handshake: a request transfers on a cycle where pN_valid and
    // pN_ready are both high; the requester holds every request field stable
    // until then. Responses are a one-cycle pN_rvalid pulse with no backpressure.
    logic            p0_valid, p0_ready, p0_we, p0_unsigned;
    logic [1:0]      p0_size;
    logic [XLEN-1:0] p0_addr, p0_wdata;
    logic            p0_rvalid, p0_err;
    logic [XLEN-1:0] p0_rdata;

    logic            p1_valid, p1_ready, p1_we, p1_unsigned;
    logic [1:0]      p1_size;
    logic [XLEN-1:0] p1_addr, p1_wdata;
    logic            p1_rvalid, p1_err;
    logic [XLEN-1:0] p1_rdata;

    logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;
    logic            mem_we;

    modport master (
        output p0_valid, p0_we, p0_unsigned, p0_size, p0_addr, p0_wdata,
        input  p0_ready, p0_rvalid, p0_err, p0_rdata,
        output p1_valid, p1_we, p1_unsigned, p1_size, p1_addr, p1_wdata,
        input  p1_ready, p1_rvalid, p1_err, p1_rdata,
        input  mem_addr, mem_wdata, mem_we,
        output mem_rdata
    );

    modport slave (
        input  p0_valid, p0_we, p0_unsigned, p0_size, p0_addr, p0_wdata,
        output p0_ready, p0_rvalid, p0_err, p0_rdata,
        input  p1_valid, p1_we, p1_unsigned, p1_size, p1_addr, p1_wdata,
        output p1_ready, p1_rvalid, p1_err, p1_rdata,
        output mem_addr, mem_wdata, mem_we,
        input  mem_rdata
    );

endinterface

// File: rtl/dmem_lane.sv
// Byte/half lane handling for one memory word: extract + extend for loads,
// and insertion of store data into the addressed lanes for read-modify-write.
module dmem_lane
    import dmem_arb_pkg::*;
(
    input  logic [XLEN-1:0] word_i,
    input  logic [1:0]      off_i,
    input  logic [1:0]      size_i,
    input  logic            unsigned_i,
    input  logic [15:0]     wdata_i,
    output logic [XLEN-1:0] load_o,
    output logic [XLEN-1:0] merge_o
);

    logic [4:0]      sh;
    logic [15:0]     lane;
    logic [XLEN-1:0] mask;
    logic [XLEN-1:0] ins;

    always_comb begin
        // Halves sit on bit 0 or 16; bytes on any multiple of 8.
        sh   = (size_i == SZ_HALF) ? {off_i[1], 4'b0000} : {off_i, 3'b000};
        lane = 16'(word_i >> sh);
        load_o = word_i;
        mask   = '0;
        ins    = '0;
        case (size_i)
            SZ_BYTE: begin
                load_o = unsigned_i ? {{(XLEN-8){1'b0}}, lane[7:0]}
                                    : {{(XLEN-8){lane[7]}}, lane[7:0]};
                mask   = {{(XLEN-8){1'b0}}, 8'hFF} << sh;
                ins    = {{(XLEN-8){1'b0}}, wdata_i[7:0]} << sh;
            end
            SZ_HALF: begin
                load_o = unsigned_i ? {{(XLEN-16){1'b0}}, lane}
                                    : {{(XLEN-16){lane[15]}}, lane};
                mask   = {{(XLEN-16){1'b0}}, 16'hFFFF} << sh;
                ins    = {{(XLEN-16){1'b0}}, wdata_i} << sh;
            end
            default: ;
        endcase
        merge_o = (word_i & ~mask) | ins;
    end

endmodule

// File: rtl/dmem_arb.sv
// Round-robin arbiter granting two requesters one-at-a-time access to a
// single-ported data memory, with sub-word stores done as read-modify-write.
module dmem_arb
    import dmem_arb_pkg::*;
#(
    parameter int MEM_BYTES = 4096
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arb_if.slave     bus,
    output state_e        state_o
);

    state_e          state_q;
    logic            last_q, gnt_q;
    logic            we_q, uns_q, err_q;
    logic [1:0]      size_q, off_q;
    logic [15:0]     wdata_q;
    logic [XLEN-1:0] mem_addr_q, mem_wdata_q;
    logic            mem_we_q;
    logic            rvalid_q, rerr_q;
    logic [XLEN-1:0] rdata_q;

    logic            any_valid, gnt_d, accept, err_d, we_d, uns_d;
    logic [1:0]      size_d;
    logic [XLEN-1:0] addr_d, wdata_d;
    logic [XLEN-1:0] load_data, merge_data;

    always_comb begin
        any_valid = bus.p0_valid | bus.p1_valid;
        // Port 1 wins when alone, or when both ask and port 0 was granted last.
        gnt_d     = bus.p1_valid && (!bus.p0_valid || !last_q);
        accept    = (state_q == IDLE) && any_valid;
        addr_d    = gnt_d ? bus.p1_addr     : bus.p0_addr;
        wdata_d   = gnt_d ? bus.p1_wdata    : bus.p0_wdata;
        we_d      = gnt_d ? bus.p1_we       : bus.p0_we;
        uns_d     = gnt_d ? bus.p1_unsigned : bus.p0_unsigned;
        size_d    = gnt_d ? bus.p1_size     : bus.p0_size;
        err_d     = bad_shape(size_d, addr_d[1:0]) || (addr_d >= XLEN'(MEM_BYTES));
    end

    assign bus.p0_ready = accept && !gnt_d;
    assign bus.p1_ready = accept &&  gnt_d;

    dmem_lane u_lane (
        .word_i     (bus.mem_rdata),
        .off_i      (off_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .wdata_i    (wdata_q),
        .load_o     (load_data),
        .merge_o    (merge_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            gnt_q       <= 1'b0;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            err_q       <= 1'b0;
            size_q      <= SZ_BYTE;
            off_q       <= 2'b00;
            wdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            rvalid_q    <= 1'b0;
            rerr_q      <= 1'b0;
            rdata_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        gnt_q      <= gnt_d;
                        last_q     <= gnt_d;
                        we_q       <= we_d;
                        uns_q      <= uns_d;
                        size_q     <= size_d;
                        off_q      <= addr_d[1:0];
                        wdata_q    <= wdata_d[15:0];
                        err_q      <= err_d;
                        mem_addr_q <= {addr_d[XLEN-1:2], 2'b00};
                        // A clean word store writes straight away in ACCESS.
                        if (we_d && size_d == SZ_WORD && !err_d) begin
                            mem_we_q    <= 1'b1;
                            mem_wdata_q <= wdata_d;
                        end
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_we_q <= 1'b0;
                    if (err_q) begin
                        rvalid_q <= 1'b1;
                        rerr_q   <= 1'b1;
                        rdata_q  <= '0;
                        state_q  <= RESP;
                    end else if (!we_q) begin
                        rvalid_q <= 1'b1;
                        rdata_q  <= load_data;
                        state_q  <= RESP;
                    end else if (size_q == SZ_WORD) begin
                        rvalid_q <= 1'b1;
                        rdata_q  <= '0;
                        state_q  <= RESP;
                    end else begin
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= merge_data;
                        state_q     <= MERGE;
                    end
                end
                MERGE: begin
                    mem_we_q <= 1'b0;
                    rvalid_q <= 1'b1;
                    rdata_q  <= '0;
                    state_q  <= RESP;
                end
                RESP: begin
                    rvalid_q <= 1'b0;
                    rerr_q   <= 1'b0;
                    rdata_q  <= '0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Reset held low during a write cycle suppresses that write as well.
    assign bus.mem_we    = mem_we_q & rst_n;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    assign bus.p0_rvalid = rvalid_q & ~gnt_q;
    assign bus.p1_rvalid = rvalid_q &  gnt_q;
    assign bus.p0_err    = rerr_q   & ~gnt_q;
    assign bus.p1_err    = rerr_q   &  gnt_q;
    assign bus.p0_rdata  = gnt_q ? '0 : rdata_q;
    assign bus.p1_rdata  = gnt_q ? rdata_q : '0;

    assign state_o = state_q;

endmodule

// File: tb/tb_dmem_arb.sv
// Bench for dmem_arb: byte-addressed reference memory and transaction-level
// expectations for grants, latency, writes and load data.
module tb_dmem_arb;
    import dmem_arb_pkg::*;

    logic   clk = 1'b0;
    logic   rst_n;
    state_e state_o;

    dmem_arb_if bus();

    dmem_arb #(.MEM_BYTES(4096)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .state_o (state_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int model_last = 1;

    logic [7:0]  ref_mem [0:4095];
    logic [31:0] mem_arr [0:1023];
    logic        bd_en   = 1'b0;
    logic [9:0]  bd_idx  = '0;
    logic [31:0] bd_data = '0;

    // Memory behind the arbiter: combinational read, write on the clock edge.
    always @(posedge clk) begin
        if (bd_en)
            mem_arr[bd_idx] <= bd_data;
        else if (bus.mem_we && bus.mem_addr < 32'd4096)
            mem_arr[bus.mem_addr[11:2]] <= bus.mem_wdata;
    end

    always_comb bus.mem_rdata = (bus.mem_addr < 32'd4096) ? mem_arr[bus.mem_addr[11:2]] : 32'h0;

    function automatic logic get_ready(input int p);
        return (p == 0) ? bus.p0_ready : bus.p1_ready;
    endfunction
    function automatic logic get_rvalid(input int p);
        return (p == 0) ? bus.p0_rvalid : bus.p1_rvalid;
    endfunction
    function automatic logic get_err(input int p);
        return (p == 0) ? bus.p0_err : bus.p1_err;
    endfunction
    function automatic logic [31:0] get_rdata(input int p);
        return (p == 0) ? bus.p0_rdata : bus.p1_rdata;
    endfunction

    task automatic set_port(input int p, input logic v, input logic we, input logic [1:0] sz,
                            input logic uns, input logic [31:0] a, input logic [31:0] wd);
        if (p == 0) begin
            bus.p0_valid = v; bus.p0_we = we; bus.p0_size = sz;
            bus.p0_unsigned = uns; bus.p0_addr = a; bus.p0_wdata = wd;
        end else begin
            bus.p1_valid = v; bus.p1_we = we; bus.p1_size = sz;
            bus.p1_unsigned = uns; bus.p1_addr = a; bus.p1_wdata = wd;
        end
    endtask

    task automatic idle_port(input int p);
        set_port(p, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic set_word(input int idx, input logic [31:0] d);
        bd_idx  = 10'(idx);
        bd_data = d;
        bd_en   = 1'b1;
        for (int b = 0; b < 4; b++) ref_mem[idx*4 + b] = d[8*b +: 8];
        @(posedge clk); #1;
        bd_en = 1'b0;
    endtask

    // Reference model: plain byte array, little-endian.
    function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
        logic [31:0] n;
        n = 32'd1 << sz;
        return (sz == 2'd3) || ((a % n) != 32'd0) || (a >= 32'd4096);
    endfunction

    function automatic logic [31:0] model_read(input int nbytes, input logic [31:0] a);
        logic [31:0] v;
        v = 32'h0;
        for (int i = 0; i < nbytes; i++) v = v | (32'(ref_mem[int'(a) + i]) << (8*i));
        return v;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns, input logic [31:0] a);
        int n;
        logic [31:0] v;
        n = 1 << sz;
        v = model_read(n, a);
        if (!uns && n < 4 && v >= (32'd1 << (8*n - 1))) v = v - (32'd1 << (8*n));
        return v;
    endfunction

    function automatic void model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        for (int i = 0; i < (1 << sz); i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
    endfunction

    task automatic run_txn(input int p, input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] rd_o, output logic [31:0] wr_o);
        logic        exp_err, exp_wr, got_err;
        logic [31:0] exp_rd, exp_wa, exp_wd, got_rd, got_wa, got_wd;
        int          exp_lat, exp_wk, n_rv, n_wr, n_orv, lat, wk;
        bit          seen, other_rdy;
        exp_err = model_err(sz, a);
        exp_wr  = we && !exp_err;
        exp_lat = (exp_wr && sz != SZ_WORD) ? 3 : 2;
        exp_wk  = exp_lat - 1;
        exp_rd  = (exp_err || we) ? 32'h0 : model_load(sz, uns, a);
        exp_wa  = 32'h0;
        exp_wd  = 32'h0;
        if (exp_wr) begin
            model_store(sz, a, wd);
            exp_wa = a & ~32'd3;
            exp_wd = model_read(4, exp_wa);
        end
        rd_o = 32'h0; wr_o = 32'h0;
        got_rd = 32'h0; got_wa = 32'h0; got_wd = 32'h0; got_err = 1'b0;
        n_rv = 0; n_wr = 0; n_orv = 0; lat = 0; wk = 0;

        @(posedge clk); #1;
        set_port(p, 1'b1, we, sz, uns, a, wd);
        seen = 0; other_rdy = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (get_ready(1 - p)) other_rdy = 1;
            if (get_ready(p)) seen = 1;
        end
        @(posedge clk); #1;
        idle_port(p);
        total++;
        if (!seen || other_rdy) begin
            bad++;
            $display("FAIL grant port%0d: ready=%0d other_ready=%0d, want 1 and 0", p, seen, other_rdy);
        end
        if (!seen) return;
        model_last = p;

        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (bus.mem_we) begin n_wr++; wk = k; got_wa = bus.mem_addr; got_wd = bus.mem_wdata; end
            if (get_rvalid(1 - p)) n_orv++;
            if (get_rvalid(p)) begin
                n_rv++;
                if (n_rv == 1) begin lat = k; got_rd = get_rdata(p); got_err = get_err(p); end
            end
        end
        rd_o = got_rd;
        wr_o = got_wd;

        total++;
        if (n_rv != 1) begin bad++; $display("FAIL rvalid_count port%0d addr=%h: got %0d want 1", p, a, n_rv); end
        total++;
        if (lat != exp_lat) begin bad++; $display("FAIL latency port%0d addr=%h: got %0d want %0d", p, a, lat, exp_lat); end
        total++;
        if (got_err !== exp_err) begin bad++; $display("FAIL err port%0d addr=%h sz=%0d: got %0b want %0b", p, a, sz, got_err, exp_err); end
        total++;
        if (got_rd !== exp_rd) begin bad++; $display("FAIL rdata port%0d addr=%h sz=%0d: got %h want %h", p, a, sz, got_rd, exp_rd); end
        total++;
        if (n_orv != 0) begin bad++; $display("FAIL other_rvalid port%0d: got %0d pulses want 0", p, n_orv); end
        total++;
        if (n_wr != int'(exp_wr)) begin bad++; $display("FAIL write_count port%0d addr=%h: got %0d want %0d", p, a, n_wr, exp_wr); end
        if (exp_wr && n_wr == 1) begin
            total++;
            if (got_wa !== exp_wa || got_wd !== exp_wd || wk != exp_wk)
                begin bad++; $display("FAIL write port%0d: got addr=%h data=%h cyc=%0d want addr=%h data=%h cyc=%0d",
                                      p, got_wa, got_wd, wk, exp_wa, exp_wd, exp_wk); end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_port(0);
        idle_port(1);
        @(posedge clk); #1;
        for (int i = 0; i < 1024; i++) set_word(i, $urandom);
        @(negedge clk);
        total++;
        if ({bus.p0_ready, bus.p1_ready, bus.p0_rvalid, bus.p1_rvalid, bus.p0_err, bus.p1_err, bus.mem_we} !== 7'b0)
            begin bad++; $display("FAIL reset_flags: got %b want 0", {bus.p0_ready, bus.p1_ready, bus.p0_rvalid,
                                  bus.p1_rvalid, bus.p0_err, bus.p1_err, bus.mem_we}); end
        total++;
        if (bus.p0_rdata !== 32'h0 || bus.p1_rdata !== 32'h0)
            begin bad++; $display("FAIL reset_rdata: got %h %h want 0", bus.p0_rdata, bus.p1_rdata); end
        total++;
        if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0)
            begin bad++; $display("FAIL reset_mem: got addr=%h wdata=%h want 0", bus.mem_addr, bus.mem_wdata); end
        total++;
        if (state_o !== IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", state_o, IDLE); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_last = 1;
    endtask

    task automatic test_load_byte();
        logic [31:0] rd, wr;
        set_word(32'h100 / 4, 32'h8899AABB);
        run_txn(0, 1'b0, SZ_BYTE, 1'b0, 32'h101, 32'h0, rd, wr);
        total++;
        if (rd !== 32'hFFFFFFAA) begin bad++; $display("FAIL load_byte_signed: got %h want ffffffaa", rd); end
    endtask

    task automatic test_store_half();
        logic [31:0] rd, wr;
        run_txn(1, 1'b1, SZ_HALF, 1'b0, 32'h102, 32'h1234, rd, wr);
        total++;
        if (wr !== 32'h1234AABB) begin bad++; $display("FAIL store_half_merge: got %h want 1234aabb", wr); end
    endtask

    task automatic test_contention();
        int order[$];
        int t_gnt[$];
        int cnt0, cnt1, first;
        bit both_rdy;
        first = (model_last == 1) ? 0 : 1;
        cnt0 = 0; cnt1 = 0; both_rdy = 0;
        @(posedge clk); #1;
        set_port(0, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0);
        set_port(1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h104, 32'h0);
        for (int k = 0; k < 40 && order.size() < 4; k++) begin
            @(negedge clk);
            if (bus.p0_ready && bus.p1_ready) both_rdy = 1;
            if (bus.p0_ready) begin order.push_back(0); t_gnt.push_back(k); cnt0++; end
            else if (bus.p1_ready) begin order.push_back(1); t_gnt.push_back(k); cnt1++; end
            @(posedge clk); #1;
            if (cnt0 >= 2) idle_port(0);
            if (cnt1 >= 2) idle_port(1);
        end
        idle_port(0);
        idle_port(1);
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (order.size() != 4 || both_rdy)
            begin bad++; $display("FAIL contention_grants: got %0d grants both=%0d want 4 and 0", order.size(), both_rdy); end
        for (int i = 0; i < order.size(); i++) begin
            total++;
            if (order[i] != (first ^ (i % 2)))
                begin bad++; $display("FAIL contention_order[%0d]: got port%0d want port%0d", i, order[i], first ^ (i % 2)); end
        end
        for (int i = 1; i < t_gnt.size(); i++) begin
            total++;
            if (t_gnt[i] - t_gnt[i-1] < 3)
                begin bad++; $display("FAIL grant_gap[%0d]: got %0d cycles want >= 3", i, t_gnt[i] - t_gnt[i-1]); end
        end
        if (order.size() > 0) model_last = order[order.size() - 1];
    endtask

    task automatic test_errors();
        logic [31:0] rd, wr;
        run_txn(0, 1'b0, SZ_WORD, 1'b0, 32'h103, 32'h0, rd, wr);
        run_txn(1, 1'b1, SZ_WORD, 1'b0, 32'h1000, 32'hCAFEF00D, rd, wr);
        run_txn(0, 1'b0, 2'd3, 1'b0, 32'h010, 32'h0, rd, wr);
        run_txn(1, 1'b1, SZ_HALF, 1'b0, 32'h0FFF, 32'hBEEF, rd, wr);
    endtask

    task automatic test_reset_merge();
        logic [31:0] rd, wr;
        int n_wr, n_rv;
        bit seen;
        n_wr = 0; n_rv = 0; seen = 0;
        @(posedge clk); #1;
        set_port(0, 1'b1, 1'b1, SZ_BYTE, 1'b0, 32'h301, 32'h5A);
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (bus.p0_ready) seen = 1;
        end
        @(posedge clk); #1;
        idle_port(0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (!seen || state_o !== MERGE)
            begin bad++; $display("FAIL rst_merge_setup: ready=%0d state=%0d want 1 and %0d", seen, state_o, MERGE); end
        n_wr += int'(bus.mem_we);
        n_rv += int'(bus.p0_rvalid | bus.p1_rvalid);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_wr += int'(bus.mem_we);
            n_rv += int'(bus.p0_rvalid | bus.p1_rvalid);
        end
        total++;
        if (n_wr != 0) begin bad++; $display("FAIL rst_merge_write: got %0d writes want 0", n_wr); end
        total++;
        if (n_rv != 0) begin bad++; $display("FAIL rst_merge_rvalid: got %0d pulses want 0", n_rv); end
        model_last = 1;
        test_contention();
        run_txn(1, 1'b0, SZ_WORD, 1'b0, 32'h300, 32'h0, rd, wr);
    endtask

    task automatic test_store_load_word();
        logic [31:0] rd, wr;
        run_txn(0, 1'b1, SZ_WORD, 1'b0, 32'h200, 32'hDEADBEEF, rd, wr);
        run_txn(0, 1'b0, SZ_HALF, 1'b1, 32'h202, 32'h0, rd, wr);
        total++;
        if (rd !== 32'h0000DEAD) begin bad++; $display("FAIL load_half_unsigned: got %h want 0000dead", rd); end
    endtask

    task automatic test_random();
        logic [31:0] rd, wr, a, m;
        logic [1:0]  sz;
        int          p;
        for (int i = 0; i < 60; i++) begin
            p  = $urandom_range(0, 1);
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, 4095));
            m  = (sz == 2'd3) ? 32'h0 : ((32'd1 << sz) - 32'd1);
            if ($urandom_range(0, 3) != 0) a = a & ~m;
            if ($urandom_range(0, 11) == 0) a = 32'($urandom_range(4096, 9000));
            run_txn(p, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, rd, wr);
        end
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_store_half();
        test_contention();
        test_errors();
        test_reset_merge();
        test_store_load_word();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
